// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter.
// This package holds the state encoding, byte-lane indices and timeout defaults.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam int BE_H32 = 3;
    localparam int BE_H24 = 2;
    localparam int BE_L16 = 1;
    localparam int BE_L8  = 0;

    localparam int unsigned TIMEOUT_CYC_DEF = 64;
    localparam int unsigned CNT_W_DEF       = 7;

    // A master is requesting when either active-low strobe is asserted.
    function automatic logic is_req(input logic rd_n, input logic wr_n);
        return ~rd_n | ~wr_n;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of master-side and matrix-side signals around the bus arbiter.
// The arbiter uses the slave modport; the environment uses the master modport.
interface bus_arbiter_if;

    logic [31:0] m0_addr;
    logic [31:0] m0_data_o;
    logic [31:0] m0_data_i;
    logic        m0_rd_n;
    logic        m0_wr_n;
    logic [3:0]  m0_be;
    logic        m0_rdy;
    logic        m0_acc_fault;

    logic [31:0] m1_addr;
    logic [31:0] m1_data_o;
    logic [31:0] m1_data_i;
    logic        m1_rd_n;
    logic        m1_wr_n;
    logic [3:0]  m1_be;
    logic        m1_rdy;
    logic        m1_acc_fault;

    logic [31:0] bus_addr;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic [3:0]  bus_be;
    logic        bus_rdy;
    logic        bus_acc_fault;

    logic [1:0]  gnt;

    modport slave (
        input  m0_addr, m0_data_o, m0_rd_n, m0_wr_n, m0_be,
        output m0_data_i, m0_rdy, m0_acc_fault,
        input  m1_addr, m1_data_o, m1_rd_n, m1_wr_n, m1_be,
        output m1_data_i, m1_rdy, m1_acc_fault,
        output bus_addr, bus_data_o, bus_rd_n, bus_wr_n, bus_be,
        input  bus_data_i, bus_rdy, bus_acc_fault,
        output gnt
    );

    modport master (
        output m0_addr, m0_data_o, m0_rd_n, m0_wr_n, m0_be,
        input  m0_data_i, m0_rdy, m0_acc_fault,
        output m1_addr, m1_data_o, m1_rd_n, m1_wr_n, m1_be,
        input  m1_data_i, m1_rdy, m1_acc_fault,
        input  bus_addr, bus_data_o, bus_rd_n, bus_wr_n, bus_be,
        output bus_data_i, bus_rdy, bus_acc_fault,
        input  gnt
    );

endinterface

// File: rtl/bus_arb_timer.sv
// Bounded-wait counter for a granted transfer: cleared while idle, counts stalled cycles.
// o_expire is high once the count reaches TIMEOUT_CYC-1.
module bus_arb_timer
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_expire = (r_cnt == LIMIT);

    // Saturate at the limit; the arbiter leaves the owning state on expiry anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of two masters access to the matrix CPU-side port.
// Define BUS_ARB_TIMEOUT_EN to abort stalled transfers with acc_fault after TIMEOUT_CYC cycles.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input logic          clk,
    input logic          rst_n,
    bus_arbiter_if.slave bus_if
);

    if (TIMEOUT_CYC < 2 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_param_err
        $error("bus_arbiter: TIMEOUT_CYC must be >= 2 and < 2**CNT_W");
    end

    arb_state_e r_state;
    arb_state_e w_state_d;
    logic       r_last_gnt;
    logic       w_last_gnt_d;

    logic        w_m0_req;
    logic        w_m1_req;
    logic        w_owning;
    logic        w_own_sel;
    logic        w_own_req;
    logic        w_expire;
    logic        w_done_rdy;
    logic        w_done_flt;

    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_data;
    logic        w_sel_rd_n;
    logic        w_sel_wr_n;
    logic [3:0]  w_sel_be;

    assign w_m0_req  = is_req(bus_if.m0_rd_n, bus_if.m0_wr_n);
    assign w_m1_req  = is_req(bus_if.m1_rd_n, bus_if.m1_wr_n);
    assign w_owning  = (r_state == ARB_OWN0) || (r_state == ARB_OWN1);
    assign w_own_sel = (r_state == ARB_OWN1);
    assign w_own_req = w_own_sel ? w_m1_req : w_m0_req;

    assign w_sel_addr = w_own_sel ? bus_if.m1_addr   : bus_if.m0_addr;
    assign w_sel_data = w_own_sel ? bus_if.m1_data_o : bus_if.m0_data_o;
    assign w_sel_rd_n = w_own_sel ? bus_if.m1_rd_n   : bus_if.m0_rd_n;
    assign w_sel_wr_n = w_own_sel ? bus_if.m1_wr_n   : bus_if.m0_wr_n;
    assign w_sel_be   = w_own_sel ? bus_if.m1_be     : bus_if.m0_be;

`ifdef BUS_ARB_TIMEOUT_EN
    bus_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_owning),
        .i_en     (w_owning && !bus_if.bus_rdy),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // last_gnt resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_last_gnt <= w_last_gnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_last_gnt_d = r_last_gnt;
        w_done_rdy   = 1'b0;
        w_done_flt   = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_m0_req && w_m1_req) begin
                    w_state_d = r_last_gnt ? ARB_OWN0 : ARB_OWN1;
                end else if (w_m0_req) begin
                    w_state_d = ARB_OWN0;
                end else if (w_m1_req) begin
                    w_state_d = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                // Priority: abort, matrix fault, completion, then timeout.
                if (!w_own_req) begin
                    w_state_d    = ARB_IDLE;
                    w_last_gnt_d = w_own_sel;
                end else if (bus_if.bus_acc_fault || (w_expire && !bus_if.bus_rdy)) begin
                    w_done_flt   = 1'b1;
                    w_state_d    = ARB_IDLE;
                    w_last_gnt_d = w_own_sel;
                end else if (bus_if.bus_rdy) begin
                    w_done_rdy   = 1'b1;
                    w_state_d    = ARB_IDLE;
                    w_last_gnt_d = w_own_sel;
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        bus_if.bus_addr     = '0;
        bus_if.bus_data_o   = '0;
        bus_if.bus_rd_n     = 1'b1;
        bus_if.bus_wr_n     = 1'b1;
        bus_if.bus_be       = '0;
        bus_if.m0_data_i    = '0;
        bus_if.m0_rdy       = 1'b0;
        bus_if.m0_acc_fault = 1'b0;
        bus_if.m1_data_i    = '0;
        bus_if.m1_rdy       = 1'b0;
        bus_if.m1_acc_fault = 1'b0;
        bus_if.gnt          = 2'b00;
        if (w_owning) begin
            bus_if.bus_addr       = w_sel_addr;
            bus_if.bus_data_o     = w_sel_data;
            bus_if.bus_rd_n       = w_sel_rd_n;
            // Both strobes low is a read, so the write strobe is masked.
            bus_if.bus_wr_n       = w_sel_wr_n | ~w_sel_rd_n;
            bus_if.bus_be[BE_H32] = w_sel_be[BE_H32];
            bus_if.bus_be[BE_H24] = w_sel_be[BE_H24];
            bus_if.bus_be[BE_L16] = w_sel_be[BE_L16];
            bus_if.bus_be[BE_L8]  = w_sel_be[BE_L8];
        end
        unique case (r_state)
            ARB_OWN0: begin
                bus_if.m0_data_i    = bus_if.bus_data_i;
                bus_if.m0_rdy       = w_done_rdy;
                bus_if.m0_acc_fault = w_done_flt;
                bus_if.gnt          = 2'b01;
            end
            ARB_OWN1: begin
                bus_if.m1_data_i    = bus_if.bus_data_i;
                bus_if.m1_rdy       = w_done_rdy;
                bus_if.m1_acc_fault = w_done_flt;
                bus_if.gnt          = 2'b10;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a model.
// Build with or without BUS_ARB_TIMEOUT_EN; the timeout scenario adapts to the build.
module tb_bus_arbiter;

    localparam int TO = 8;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if bif ();

    bus_arbiter #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bif)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus (-1 = nobody), who last finished, cycles owned so far.
    int m_owner, m_last, m_owned;
    int n_owner, n_last, n_owned;
    bit comp [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ma(input int x);
        return (x == 1) ? bif.m1_addr : bif.m0_addr;
    endfunction
    function automatic logic [31:0] md(input int x);
        return (x == 1) ? bif.m1_data_o : bif.m0_data_o;
    endfunction
    function automatic logic mrd(input int x);
        return (x == 1) ? bif.m1_rd_n : bif.m0_rd_n;
    endfunction
    function automatic logic mwr(input int x);
        return (x == 1) ? bif.m1_wr_n : bif.m0_wr_n;
    endfunction
    function automatic logic [3:0] mbe(input int x);
        return (x == 1) ? bif.m1_be : bif.m0_be;
    endfunction

    task automatic set_m(input int x, input logic rd_n, input logic wr_n, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (x == 0) begin
            bif.m0_rd_n = rd_n; bif.m0_wr_n = wr_n; bif.m0_addr = a;
            bif.m0_data_o = d; bif.m0_be = be;
        end else begin
            bif.m1_rd_n = rd_n; bif.m1_wr_n = wr_n; bif.m1_addr = a;
            bif.m1_data_o = d; bif.m1_be = be;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_owned = 0;
        comp[0] = 1'b0; comp[1] = 1'b0;
    endtask

    task automatic model_check();
        logic r0, r1, rq;
        logic [31:0] e_addr, e_do;
        logic        e_rd, e_wr;
        logic [3:0]  e_be;
        logic [1:0]  e_gnt;
        logic [31:0] e_di [2];
        logic        e_rdy [2];
        logic        e_flt [2];
        int x;
        e_addr = '0; e_do = '0; e_rd = 1'b1; e_wr = 1'b1; e_be = '0; e_gnt = 2'b00;
        for (int i = 0; i < 2; i++) begin
            e_di[i] = '0; e_rdy[i] = 1'b0; e_flt[i] = 1'b0;
        end
        r0 = !bif.m0_rd_n || !bif.m0_wr_n;
        r1 = !bif.m1_rd_n || !bif.m1_wr_n;
        n_owner = m_owner; n_last = m_last; n_owned = m_owned;
        if (m_owner < 0) begin
            n_owned = 0;
            if (r0 && r1) n_owner = 1 - m_last;
            else if (r0) n_owner = 0;
            else if (r1) n_owner = 1;
        end else begin
            x = m_owner;
            rq = (x == 1) ? r1 : r0;
            e_gnt = (x == 1) ? 2'b10 : 2'b01;
            e_addr = ma(x); e_do = md(x); e_rd = mrd(x); e_be = mbe(x);
            e_wr = (mrd(x) == 1'b0) ? 1'b1 : mwr(x);
            e_di[x] = bif.bus_data_i;
            if (!rq) begin
                n_owner = -1; n_last = x;
            end else begin
                if (bif.bus_acc_fault) e_flt[x] = 1'b1;
                else if (bif.bus_rdy) e_rdy[x] = 1'b1;
                else if (TO_EN && (m_owned + 1 == TO)) e_flt[x] = 1'b1;
                else n_owned = m_owned + 1;
                if (e_rdy[x] || e_flt[x]) begin
                    n_owner = -1; n_last = x;
                end
            end
        end
        check_eq("gnt", 32'(bif.gnt), 32'(e_gnt));
        check_eq("bus_addr", bif.bus_addr, e_addr);
        check_eq("bus_data_o", bif.bus_data_o, e_do);
        check_eq("bus_rd_n", 32'(bif.bus_rd_n), 32'(e_rd));
        check_eq("bus_wr_n", 32'(bif.bus_wr_n), 32'(e_wr));
        check_eq("bus_be", 32'(bif.bus_be), 32'(e_be));
        check_eq("m0_data_i", bif.m0_data_i, e_di[0]);
        check_eq("m1_data_i", bif.m1_data_i, e_di[1]);
        check_eq("m0_rdy", 32'(bif.m0_rdy), 32'(e_rdy[0]));
        check_eq("m1_rdy", 32'(bif.m1_rdy), 32'(e_rdy[1]));
        check_eq("m0_acc_fault", 32'(bif.m0_acc_fault), 32'(e_flt[0]));
        check_eq("m1_acc_fault", 32'(bif.m1_acc_fault), 32'(e_flt[1]));
        comp[0] = e_rdy[0] || e_flt[0];
        comp[1] = e_rdy[1] || e_flt[1];
    endtask

    // Called at a falling edge with inputs settled; returns at the next falling edge.
    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        m_owner = n_owner; m_last = n_last; m_owned = n_owned;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic new_req(input int x);
        int op;
        op = $urandom_range(0, 5);
        if (op <= 2) set_m(x, 1'b0, 1'b1, $urandom, $urandom, 4'($urandom));
        else if (op <= 4) set_m(x, 1'b1, 1'b0, $urandom, $urandom, 4'($urandom));
        else set_m(x, 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
    endtask

    task automatic rand_step();
        bit busy;
        for (int x = 0; x < 2; x++) begin
            busy = (mrd(x) == 1'b0) || (mwr(x) == 1'b0);
            if (busy && comp[x]) begin
                if ($urandom_range(0, 1) == 1) new_req(x);
                else set_m(x, 1'b1, 1'b1, '0, '0, '0);
            end else if (busy && $urandom_range(0, 99) == 0) begin
                set_m(x, 1'b1, 1'b1, '0, '0, '0);
            end else if (!busy && $urandom_range(0, 2) == 0) begin
                new_req(x);
            end
        end
        bif.bus_rdy       = ($urandom_range(0, 3) == 0);
        bif.bus_acc_fault = ($urandom_range(0, 39) == 0);
        bif.bus_data_i    = $urandom;
    endtask

    initial begin
        int rr_q[$];
        int fault_k, gnt1_k;

        set_m(0, 1'b1, 1'b1, '0, '0, '0);
        set_m(1, 1'b1, 1'b1, '0, '0, '0);
        bif.bus_rdy = 1'b0; bif.bus_acc_fault = 1'b0; bif.bus_data_i = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check_eq("rst_gnt", 32'(bif.gnt), 32'd0);
        check_eq("rst_bus_rd_n", 32'(bif.bus_rd_n), 32'd1);
        check_eq("rst_bus_wr_n", 32'(bif.bus_wr_n), 32'd1);
        check_eq("rst_bus_be", 32'(bif.bus_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single m0 read
        set_m(0, 1'b0, 1'b1, 32'h0000_A004, '0, 4'hF);
        bif.bus_rdy = 1'b1; bif.bus_data_i = 32'h1234_5678;
        #1;
        check_eq("t1_req_gnt", 32'(bif.gnt), 32'd0);
        tick();
        #1;
        check_eq("t1_gnt", 32'(bif.gnt), 32'd1);
        check_eq("t1_rdy", 32'(bif.m0_rdy), 32'd1);
        check_eq("t1_data", bif.m0_data_i, 32'h1234_5678);
        check_eq("t1_addr", bif.bus_addr, 32'h0000_A004);
        tick();
        set_m(0, 1'b1, 1'b1, '0, '0, '0);
        #1;
        check_eq("t1_gnt_after", 32'(bif.gnt), 32'd0);
        tick();

        // Round-robin from reset with both masters requesting continuously
        do_reset();
        set_m(0, 1'b0, 1'b1, 32'h100, '0, 4'hF);
        set_m(1, 1'b0, 1'b1, 32'h200, '0, 4'hF);
        for (int c = 0; c < 20 && rr_q.size() < 6; c++) begin
            #1;
            if (bif.m0_rdy) rr_q.push_back(0);
            if (bif.m1_rdy) rr_q.push_back(1);
            tick();
        end
        check_eq("rr_count", 32'(rr_q.size()), 32'd6);
        foreach (rr_q[i]) check_eq("rr_order", 32'(rr_q[i]), 32'(i % 2));
        set_m(0, 1'b1, 1'b1, '0, '0, '0);
        set_m(1, 1'b1, 1'b1, '0, '0, '0);
        tick();

        // m1 write with m0 idle
        set_m(1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 4'b0011);
        bif.bus_rdy = 1'b0; bif.bus_data_i = 32'hA5A5_A5A5;
        tick();
        #1;
        check_eq("t3_gnt", 32'(bif.gnt), 32'd2);
        check_eq("t3_wr_n", 32'(bif.bus_wr_n), 32'd0);
        check_eq("t3_rd_n", 32'(bif.bus_rd_n), 32'd1);
        check_eq("t3_data_o", bif.bus_data_o, 32'hDEAD_BEEF);
        check_eq("t3_be", 32'(bif.bus_be), 32'd3);
        check_eq("t3_addr", bif.bus_addr, 32'hFFFF_FFFC);
        check_eq("t3_m0_rdy", 32'(bif.m0_rdy), 32'd0);
        check_eq("t3_m0_data", bif.m0_data_i, 32'd0);
        tick();
        bif.bus_rdy = 1'b1;
        #1;
        check_eq("t3_m1_rdy", 32'(bif.m1_rdy), 32'd1);
        tick();
        set_m(1, 1'b1, 1'b1, '0, '0, '0);
        bif.bus_rdy = 1'b0;
        tick();

        // Stalled m0 transfer with m1 waiting
        set_m(0, 1'b0, 1'b1, 32'h40, '0, 4'hF);
        set_m(1, 1'b0, 1'b1, 32'h80, '0, 4'hF);
        tick();
        fault_k = -1; gnt1_k = -1;
        for (int k = 1; k <= 130; k++) begin
            #1;
            if (fault_k < 0 && bif.m0_acc_fault) fault_k = k;
            if (gnt1_k < 0 && bif.gnt == 2'b10) gnt1_k = k;
            tick();
            if (fault_k == k) set_m(0, 1'b1, 1'b1, '0, '0, '0);
            if (gnt1_k >= 0) break;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        check_eq("to_fault_cycle", 32'(fault_k), 32'd8);
        check_eq("to_next_gnt", 32'(gnt1_k), 32'd10);
`else
        check_eq("nt_no_fault", 32'(fault_k), 32'hFFFF_FFFF);
        check_eq("nt_gnt_held", 32'(bif.gnt), 32'd1);
`endif
        set_m(0, 1'b1, 1'b1, '0, '0, '0);
        set_m(1, 1'b1, 1'b1, '0, '0, '0);
        tick();
        tick();

        // Reset while m1 owns the bus with three stalled cycles behind it
        set_m(1, 1'b0, 1'b1, 32'h300, '0, 4'hF);
        tick();
        tick(); tick(); tick();
        rst_n = 1'b0;
        set_m(0, 1'b0, 1'b1, 32'h400, '0, 4'hF);
        #1;
        check_eq("rst_mid_gnt", 32'(bif.gnt), 32'd0);
        check_eq("rst_mid_rd_n", 32'(bif.bus_rd_n), 32'd1);
        check_eq("rst_mid_addr", bif.bus_addr, 32'd0);
        check_eq("rst_mid_m1_data", bif.m1_data_i, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_m(1, 1'b1, 1'b1, '0, '0, '0);
        tick();
        #1;
        check_eq("rst_regrant", 32'(bif.gnt), 32'd1);
        bif.bus_rdy = 1'b1;
        tick();
        set_m(0, 1'b1, 1'b1, '0, '0, '0);
        tick();

        // Matrix fault on an m0 transfer
        set_m(0, 1'b0, 1'b1, 32'h500, '0, 4'hF);
        bif.bus_acc_fault = 1'b1;
        tick();
        #1;
        check_eq("af_fault", 32'(bif.m0_acc_fault), 32'd1);
        check_eq("af_rdy", 32'(bif.m0_rdy), 32'd0);
        tick();
        set_m(0, 1'b1, 1'b1, '0, '0, '0);
        bif.bus_acc_fault = 1'b0;
        #1;
        check_eq("af_idle", 32'(bif.gnt), 32'd0);
        tick();

        // Random traffic
        comp[0] = 1'b0; comp[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rand_step();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the address-decode matrix's CPU-side port.
- Master 0 is the CPU load/store port; master 1 is a DMA/debug master.
- Grants one master at a time and forwards that master's address, data, strobes and byte lanes to the matrix.
- Returns the matrix's rdy/rdata to the granted master only; round-robin between masters; bounded-wait timeout raises acc_fault.

Parameters:
- TIMEOUT_CYC, 64, cycles a granted transfer may wait for bus_rdy before being aborted with a fault (min 2).
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m{0,1}_addr  in  32  master byte address
- m{0,1}_data_o  in  32  master write data
- m{0,1}_data_i  out  32  read data to master; 0 when not granted
- m{0,1}_rd_n  in  1  active-low read request
- m{0,1}_wr_n  in  1  active-low write request
- m{0,1}_be  in  4  byte lanes {h32,h24,l16,l8}
- m{0,1}_rdy  out  1  transfer-complete pulse to master
- m{0,1}_acc_fault  out  1  fault pulse to master (timeout or matrix fault)
- bus_addr  out  32  to matrix addr_cpu
- bus_data_o  out  32  to matrix data_o_cpu
- bus_data_i  in  32  from matrix data_i_cpu
- bus_rd_n  out  1  to matrix rd_n_cpu
- bus_wr_n  out  1  to matrix wr_n_cpu
- bus_be  out  4  to matrix {h32,h24,l16,l8}
- bus_rdy  in  1  from matrix rdy_cpu
- bus_acc_fault  in  1  from matrix acc_fault
- gnt  out  2  one-hot current grant, for debug/trace

Behaviour:
- Request: mX_req = !mX_rd_n | !mX_wr_n. Both strobes low simultaneously counts as a read (wr suppressed).
- States: IDLE, OWN0, OWN1. Registered; last_gnt is a 1-bit register.
- IDLE:
  - Single requester -> grant it.
  - Both requesting -> grant the master that is not last_gnt.
  - No requester -> stay.
  - Transition takes effect next cycle; the bus is driven from that cycle (1-cycle arbitration latency).
- OWNx:
  - bus_* = mX_* combinationally; non-granted master sees data_i=0, rdy=0, fault=0.
  - In IDLE: bus_rd_n=bus_wr_n=1, bus_be=0, bus_addr=0, bus_data_o=0.
- Completion: in OWNx with bus_rdy=1 -> mX_rdy=1 and mX_data_i=bus_data_i that same cycle. Next state IDLE, last_gnt<=x. The master must hold its request stable until it sees rdy.
- Master drops its request while owning (abort) -> next state IDLE, no rdy/fault, last_gnt<=x.
- bus_acc_fault=1 while owning -> mX_acc_fault=1 (rdy suppressed that cycle), then IDLE.
- Back-to-back: a master requesting again after its rdy re-arbitrates from IDLE; the other master wins if waiting. Minimum 2 cycles per transfer.
- Timeout counter (see Optional Feature): cleared on grant entry, increments each owning cycle without bus_rdy. Reaching TIMEOUT_CYC-1 with no bus_rdy -> mX_acc_fault pulse, next IDLE. bus_rdy in the same cycle as expiry wins (normal completion).
- Reset (any time, incl. mid-transfer): state IDLE, last_gnt=1 (master 0 wins first tie), counter 0, gnt=2'b00, all mX_rdy/fault=0, all bus strobes deasserted high.
- gnt: 01 in OWN0, 10 in OWN1, 00 in IDLE.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN.
- Defined: timeout counter and fault generation as above.
- Undefined: no counter; a granted transfer waits indefinitely for bus_rdy or bus_acc_fault; mX_acc_fault only mirrors bus_acc_fault.

Decomposition:
- Shared package/include holds:
  - state encodings ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2
  - byte-lane index constants BE_H32=3, BE_H24=2, BE_L16=1, BE_L8=0
  - default TIMEOUT_CYC
- One sub-module: bus_arb_timer (counter with clear/enable/expire), instantiated only under BUS_ARB_TIMEOUT_EN.

Test Plan:
- Single m0 read addr 0x0000A004, bus_rdy held 1, bus_data_i=0x12345678 -> gnt=01 one cycle after request, m0_rdy=1 with m0_data_i=0x12345678 same cycle, gnt=00 next.
- m0 and m1 request in same cycle from reset -> m0 granted first. After m0 completes, m1 granted; after m1 completes with both still requesting -> m0 granted (round-robin alternation over 6 transfers: 0,1,0,1,0,1).
- m1 write 0xDEADBEEF to 0xFFFFFFFC, be=4'b0011 -> bus_wr_n=0, bus_data_o=0xDEADBEEF, bus_be=0011 while OWN1; m0 sees rdy=0, data_i=0.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, bus_rdy stuck 0 -> m0_acc_fault pulses exactly 8 cycles after grant, state returns IDLE, m1 then granted. Without the macro -> no fault, grant held for 100+ cycles.
- rst_n asserted low mid-transfer (OWN1, counter=3) -> outputs immediately deasserted, gnt=00; after release a pending m0 request is granted one cycle later.
- bus_acc_fault=1 on m0 transfer -> m0_acc_fault=1, m0_rdy=0 that cycle, state IDLE next.
